// File: rtl/sram_like_responder_pkg.sv
// Shared definitions for the SRAM-like responder: access size codes,
// default store depth and the byte-lane merge used on writes.
package sram_like_responder_pkg;

  localparam int DEFAULT_DEPTH_LOG2 = 10;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Code 3 is an alias of a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_like_responder_req_fifo.sv
// Two-entry in-order request queue. Storage carries no reset; only the
// pointers and occupancy are cleared, which is enough to discard entries.
import sram_like_responder_pkg::*;

module sram_req_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] slot_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = slot_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slot_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like target: accepts requests into a 2-deep queue, waits cfg_delay
// cycles per head entry, then services it against a word-wide backing store.
import sram_like_responder_pkg::*;

module sram_like_responder #(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  cfg_delay,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = 1 + 4 + DEPTH_LOG2 + 32;

  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  head_wr;
  logic [3:0]            head_strb;
  logic [DEPTH_LOG2-1:0] head_idx;
  logic [31:0]           head_wdata;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  load_cnt;

  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  data_ok_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_q [DEPTH];

  // Handshake: a request transfers on a rising edge where req && addr_ok.
  // addr_ok only reflects registered occupancy (and reset), never req or a pop.
  assign addr_ok = resetn & ~fifo_full;
  assign push    = req & addr_ok;
  assign pop     = resetn & ~fifo_empty & (wait_cnt_q == 4'd0);

  // A new head appears on push into empty, or on pop with something behind it
  // (either already queued or arriving on the same edge).
  assign load_cnt = (push & fifo_empty) | (pop & (fifo_full | push));

  assign push_entry = {wr, wstrb, addr[DEPTH_LOG2+1:2], wdata};
  assign {head_wr, head_strb, head_idx, head_wdata} = head_entry;

  sram_req_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (load_cnt) begin
      wait_cnt_d = cfg_delay;
    end else if (wait_cnt_q != 4'd0) begin
      wait_cnt_d = wait_cnt_q - 4'd1;
    end

    rdata_d = rdata_q;
    if (pop) begin
      rdata_d = head_wr ? 32'h0 : mem_q[head_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt_q <= 4'd0;
      data_ok_q  <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      data_ok_q  <= pop;
      rdata_q    <= rdata_d;
    end
  end

  // Store is never reset; a later read sees this write on the very next edge.
  always_ff @(posedge clk) begin
    if (pop && head_wr) begin
      mem_q[head_idx] <= merge_bytes(mem_q[head_idx], head_wdata, head_strb);
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;

  // rdata is always the full word; size and sub-word address bits do not matter here.
  logic unused_bits;
  assign unused_bits = ^{size_bytes(size), addr[31:DEPTH_LOG2+2], addr[1:0]};

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: reset, latency, byte strobes,
// backpressure, mid-operation reset and streaming.
module tb_sram_like_responder;
  import sram_like_responder_pkg::*;

  logic        clk;
  logic        resetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  cfg_delay;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [31:0] exp_q[$];

  sram_like_responder dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .wstrb     (wstrb),
    .addr      (addr),
    .wdata     (wdata),
    .cfg_delay (cfg_delay),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Single access into an otherwise idle queue. lat counts cycles from the
  // accepting edge: the first cycle after it is 1. lat = -1 on any timeout.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat);
    bit acc;
    @(posedge clk); #1;
    req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
    acc = 1'b0; lat = -1; rd = 32'hxxxxxxxx;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (addr_ok) acc = 1'b1;
      @(posedge clk); #1;
    end
    req = 1'b0;
    if (acc) begin
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (data_ok) begin
          lat = i;
          rd  = rdata;
          break;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = SZ_WORD; wstrb = 4'h0;
    addr = 32'h0; wdata = 32'h0; cfg_delay = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok: got %b expected 0", addr_ok); end
    checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b expected 0", data_ok); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL release_addr_ok: got %b expected 1", addr_ok); end
  endtask

  task automatic test_write_then_read();
    cfg_delay = 4'd0;
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; addr = 32'h1c000000; wdata = 32'hdeadbeef; wstrb = 4'hf;
    @(negedge clk);
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL wtr_c1_addr_ok: got %b expected 1", addr_ok); end
    @(posedge clk); #1;
    wr = 1'b0; wdata = 32'h0; wstrb = 4'h0;
    @(negedge clk);
    checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL wtr_c2_data_ok: got %b expected 0", data_ok); end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL wtr_c3_data_ok: got %b expected 1", data_ok); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL wtr_c3_rdata: got %h expected 00000000", rdata); end
    @(negedge clk);
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL wtr_c4_data_ok: got %b expected 1", data_ok); end
    checks++; if (rdata !== 32'hdeadbeef) begin errors++; $display("FAIL wtr_c4_rdata: got %h expected deadbeef", rdata); end
    @(negedge clk);
    checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL wtr_c5_data_ok: got %b expected 0", data_ok); end
    checks++; if (rdata !== 32'hdeadbeef) begin errors++; $display("FAIL wtr_c5_rdata_hold: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd;
    int lat;
    cfg_delay = 4'd0;
    access(1'b1, 32'h00000040, 32'h11223344, 4'hf, rd, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL bs_write_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL bs_write_rdata: got %h expected 00000000", rd); end
    access(1'b1, 32'h00000040, 32'haabbccdd, 4'b0010, rd, lat);
    size = SZ_BYTE;
    // Upper address bits lie outside the store and must alias to the same word.
    access(1'b0, 32'hf0000041, 32'h0, 4'hf, rd, lat);
    size = SZ_WORD;
    checks++; if (rd !== 32'h1122cc44) begin errors++; $display("FAIL bs_merge_rdata: got %h expected 1122cc44", rd); end
  endtask

  task automatic test_latency();
    logic [31:0] rd;
    int lat;
    int extra;
    cfg_delay = 4'd5;
    access(1'b0, 32'h1c000000, 32'h0, 4'h0, rd, lat);
    checks++; if (lat != 7) begin errors++; $display("FAIL lat_delay5: got %0d expected 7", lat); end
    checks++; if (rd !== 32'hdeadbeef) begin errors++; $display("FAIL lat_delay5_rdata: got %h expected deadbeef", rd); end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_ok) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL lat_single_pulse: got %0d extra pulses expected 0", extra); end
    cfg_delay = 4'd15;
    access(1'b0, 32'h00000040, 32'h0, 4'h0, rd, lat);
    checks++; if (lat != 17) begin errors++; $display("FAIL lat_delay15: got %0d expected 17", lat); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic [31:0] exp_word;
    int lat;
    int n_acc;
    int n_resp;
    int first_low_acc;
    int resp_cyc[4];
    bit hs;
    cfg_delay = 4'd0;
    for (int i = 0; i < 4; i++) access(1'b1, 32'h800 + 4*i, 32'ha0a00000 + i, 4'hf, rd, lat);
    cfg_delay = 4'd3;
    exp_q = {};
    n_acc = 0; n_resp = 0; first_low_acc = -1;
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; addr = 32'h800;
    for (int c = 0; c < 80 && n_resp < 4; c++) begin
      @(negedge clk);
      if (req && !addr_ok && first_low_acc < 0) first_low_acc = n_acc;
      if (data_ok) begin
        exp_word = 32'hxxxxxxxx;
        if (exp_q.size() != 0) exp_word = exp_q.pop_front();
        checks++; if (rdata !== exp_word) begin errors++; $display("FAIL bp_rdata_%0d: got %h expected %h", n_resp, rdata, exp_word); end
        resp_cyc[n_resp] = cyc;
        n_resp++;
      end
      hs = req && addr_ok;
      @(posedge clk); #1;
      if (hs) begin
        exp_q.push_back(32'ha0a00000 + n_acc);
        n_acc++;
        if (n_acc == 4) req = 1'b0;
        else addr = 32'h800 + 4*n_acc;
      end
    end
    req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (data_ok) n_resp++;
    end
    checks++; if (first_low_acc != 2) begin errors++; $display("FAIL bp_addr_ok_low: got low after %0d accepts expected 2", first_low_acc); end
    checks++; if (n_resp != 4) begin errors++; $display("FAIL bp_resp_count: got %0d expected 4", n_resp); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (resp_cyc[i] - resp_cyc[i-1] != 4) begin
        errors++; $display("FAIL bp_spacing_%0d: got %0d expected 4", i, resp_cyc[i] - resp_cyc[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int lat;
    int pulses;
    cfg_delay = 4'd0;
    access(1'b1, 32'h00000100, 32'h0badf00d, 4'hf, rd, lat);
    cfg_delay = 4'd8;
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'hffffffff; wstrb = 4'hf;
    @(posedge clk); #1;
    addr = 32'h100; wdata = 32'h0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL rm_addr_ok_in_reset: got %b expected 0", addr_ok); end
    @(posedge clk); #1;
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_ok) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rm_no_data_ok: got %0d pulses expected 0", pulses); end
    cfg_delay = 4'd0;
    access(1'b0, 32'h00000040, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h1122cc44) begin errors++; $display("FAIL rm_old_word40: got %h expected 1122cc44", rd); end
    access(1'b0, 32'h00000100, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h0badf00d) begin errors++; $display("FAIL rm_old_word100: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_streaming();
    logic [31:0] rd;
    logic [31:0] exp_word;
    int lat;
    int n_acc;
    int n_resp;
    int lows;
    int first_cyc;
    int last_cyc;
    bit hs;
    cfg_delay = 4'd0;
    for (int i = 0; i < 16; i++) access(1'b1, 32'h400 + 4*i, 32'h50000000 + 32'h01010101 * i, 4'hf, rd, lat);
    exp_q = {};
    n_acc = 0; n_resp = 0; lows = 0; first_cyc = -1; last_cyc = -1;
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b0; addr = 32'h400;
    for (int c = 0; c < 60 && n_resp < 16; c++) begin
      @(negedge clk);
      if (req && !addr_ok) lows++;
      if (data_ok) begin
        exp_word = 32'hxxxxxxxx;
        if (exp_q.size() != 0) exp_word = exp_q.pop_front();
        checks++; if (rdata !== exp_word) begin errors++; $display("FAIL st_rdata_%0d: got %h expected %h", n_resp, rdata, exp_word); end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n_resp++;
      end
      hs = req && addr_ok;
      @(posedge clk); #1;
      if (hs) begin
        exp_q.push_back(32'h50000000 + 32'h01010101 * n_acc);
        n_acc++;
        if (n_acc == 16) req = 1'b0;
        else addr = 32'h400 + 4*n_acc;
      end
    end
    req = 1'b0;
    checks++; if (n_resp != 16) begin errors++; $display("FAIL st_resp_count: got %0d expected 16", n_resp); end
    checks++; if (last_cyc - first_cyc != 15) begin errors++; $display("FAIL st_consecutive: got span %0d expected 15", last_cyc - first_cyc); end
    checks++; if (lows != 0) begin errors++; $display("FAIL st_addr_ok_low: got %0d low cycles expected 0", lows); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_then_read();
    test_byte_strobe();
    test_latency();
    test_backpressure();
    test_reset_mid();
    test_streaming();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_responder.md
SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the backing-store word count (1024 x 32-bit).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req  input  1  initiator request valid.
REQ-005 SHALL have port wr  input  1  1 = write, 0 = read.
REQ-006 SHALL have port size  input  2  access size: 0 byte, 1 half, 2 word; 3 is treated as 2.
REQ-007 SHALL have port wstrb  input  4  byte write strobes; ignored for reads.
REQ-008 SHALL have port addr  input  32  byte address; the word index is addr[DEPTH_LOG2+1:2]; all other bits are ignored.
REQ-009 SHALL have port wdata  input  32  write data, byte-lane aligned.
REQ-010 SHALL have port cfg_delay  input  4  extra response wait cycles, 0..15.
REQ-011 SHALL have port addr_ok  output  1  request accepted when req & addr_ok at a rising edge.
REQ-012 SHALL have port data_ok  output  1  single-cycle response pulse, registered.
REQ-013 SHALL have port rdata  output  32  read data, valid only while data_ok is high, registered.

Function
REQ-014 SHALL hold accepted requests in a 2-entry in-order queue storing {wr, wstrb, word index, wdata}.
REQ-015 SHALL drive addr_ok = (queue occupancy < 2); addr_ok SHALL NOT depend combinationally on req or on a same-cycle pop.
REQ-016 SHALL load a wait counter with cfg_delay at the edge on which an entry becomes queue head (push into an empty queue, or pop with an entry behind it).
REQ-017 SHALL decrement the counter each cycle while it is nonzero; the head SHALL be serviced in the cycle the counter is 0.
REQ-018 Servicing SHALL, at one edge, pop the head, set data_ok=1, and set rdata = mem[index] for reads or 32'h0 for writes; for writes, each byte with wstrb[i]=1 SHALL be written to mem[index] and all other bytes kept.
REQ-019 A handshake in cycle N SHALL give data_ok in cycle N+2+cfg_delay when the queue was empty; in-order completion SHALL always hold.
REQ-020 With cfg_delay=0 and req held high, SHALL sustain one response per cycle after the first.
REQ-021 A read SHALL observe every earlier-accepted write to the same word, including a write serviced in the immediately preceding cycle.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged; a push at occupancy 2 SHALL be impossible, because addr_ok is low.
REQ-023 data_ok SHALL deassert in any cycle with no service; rdata SHALL hold its last value.
REQ-024 size SHALL NOT alter rdata, which is always the full word; the initiator extracts bytes.

Reset
REQ-025 While resetn=0, SHALL clear the queue, the counter and data_ok to 0, set rdata to 32'h0, and drive addr_ok to 0.
REQ-026 Reset mid-operation SHALL discard queued requests without applying their writes and without producing a data_ok.
REQ-027 Backing-store contents SHALL NOT be reset.
REQ-028 addr_ok SHALL be 1 in the first cycle after resetn returns to 1.

Structure
REQ-029 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the default DEPTH_LOG2.
REQ-030 The queue SHALL be a sub-module named sram_req_fifo (2 entries, push/pop/full/empty); the counter, backing store and response registers stay in the top module.

Verification
REQ-031 Write-then-read, cfg_delay=0: write addr 0x1c000000 wdata 0xdeadbeef wstrb 4'hf in cycle 1, then read the same address in cycle 2 -> data_ok in cycles 3 and 4, rdata 0x00000000 then 0xdeadbeef.
REQ-032 Byte strobe: word holds 0x11223344, write wdata 0xaabbccdd wstrb 4'b0010, then read -> rdata 0x1122cc44.
REQ-033 Latency: cfg_delay=5, single read accepted in cycle 10 -> data_ok only in cycle 17.
REQ-034 Backpressure: cfg_delay=3, req held high for 4 reads -> addr_ok low after 2 accepts, each response 4 cycles apart, order preserved, 4 data_ok total.
REQ-035 Reset mid-operation: 2 writes queued with cfg_delay=8, resetn=0 for 1 cycle -> no data_ok; later reads return the old contents.
REQ-036 Streaming: cfg_delay=0, 16 consecutive reads -> 16 consecutive data_ok cycles, addr_ok never low.
